// File: rtl/rice_bit_aligner_pkg.sv
// rtl/rice_bit_aligner_pkg.sv - shared constants, types and bit-reversal helpers for the Rice bit aligner
// Package rice_pkg: widths of the word/window, bit buffer, bit counter and consume length,
// plus bit-reversal functions used to express right shifts on left-only shifters.
package rice_pkg;

  localparam int WORD_W = 32;
  localparam int BUF_W  = 64;
  localparam int CNT_W  = 7;
  localparam int LEN_W  = 6;

  typedef logic [CNT_W-1:0] bitcnt_t;
  typedef logic [LEN_W-1:0] conslen_t;

  function automatic logic [WORD_W-1:0] rev32(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[i] = x[WORD_W-1-i];
    return r;
  endfunction

  function automatic logic [BUF_W-1:0] rev64(input logic [BUF_W-1:0] x);
    logic [BUF_W-1:0] r;
    for (int i = 0; i < BUF_W; i++) r[i] = x[BUF_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/rice_bit_aligner_if.sv
// rtl/rice_bit_aligner_if.sv - stream/window handshake bundle between source, decoder and aligner
// Signals:
//   in_word/in_valid/in_ready : packed input words (bit 31 first in stream order)
//   win/win_valid/win_bits    : left-aligned 32-bit decode window
//   cons_en/cons_len          : variable-length consume request
//   flush                     : end-of-stream partial-window request
//   err                       : sticky illegal-consume flag
// master = source/decoder side, slave = aligner.
interface rice_bit_aligner_if;
  import rice_pkg::*;

  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] win;
  logic              win_valid;
  conslen_t          win_bits;
  logic              cons_en;
  conslen_t          cons_len;
  logic              flush;
  logic              err;

  modport master (
    output in_word, in_valid, cons_en, cons_len, flush,
    input  in_ready, win, win_valid, win_bits, err
  );

  modport slave (
    input  in_word, in_valid, cons_en, cons_len, flush,
    output in_ready, win, win_valid, win_bits, err
  );

endinterface

// File: rtl/rice_bit_aligner_leftshifter.sv
// rtl/rice_bit_aligner_leftshifter.sv - 32-bit logical left shifter, 5-bit shift amount
// Ports:
//   data_i  in  32  value to shift
//   shamt_i in  5   shift amount 0..31
//   data_o  out 32  data_i << shamt_i, zero filled
module leftshifter
  import rice_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [4:0]        shamt_i,
  output logic [WORD_W-1:0] data_o
);

  assign data_o = data_i << shamt_i;

endmodule

// File: rtl/rice_bit_aligner_shift64.sv
// rtl/rice_bit_aligner_shift64.sv - 64-bit left shift by 0..64 built from three 32-bit leftshifters
// Ports:
//   data_i  in  64  value to shift
//   shamt_i in  7   shift amount 0..64 (>=64 yields zero)
//   data_o  out 64  data_i << shamt_i
// The bits carried from the low half into the high half are lo >> (32-s), produced as
// rev(rev(lo) << (32-s)) so that only left shifters are needed. Shifts of 32..63 reuse the
// low-half shifter output as a half-word select instead of a wider shift amount.
module rice_shift64
  import rice_pkg::*;
(
  input  logic [BUF_W-1:0] data_i,
  input  bitcnt_t          shamt_i,
  output logic [BUF_W-1:0] data_o
);

  logic [WORD_W-1:0] hi_sh;
  logic [WORD_W-1:0] lo_sh;
  logic [WORD_W-1:0] cy_rev_sh;
  logic [WORD_W-1:0] carry;
  logic [4:0]        neg_sh;

  assign neg_sh = 5'd0 - shamt_i[4:0];

  leftshifter u_hi (
    .data_i  (data_i[BUF_W-1:WORD_W]),
    .shamt_i (shamt_i[4:0]),
    .data_o  (hi_sh)
  );

  leftshifter u_lo (
    .data_i  (data_i[WORD_W-1:0]),
    .shamt_i (shamt_i[4:0]),
    .data_o  (lo_sh)
  );

  leftshifter u_carry (
    .data_i  (rev32(data_i[WORD_W-1:0])),
    .shamt_i (neg_sh),
    .data_o  (cy_rev_sh)
  );

  // A zero low-order shift amount carries nothing across the halves.
  assign carry = (shamt_i[4:0] != 5'd0) ? rev32(cy_rev_sh) : '0;

  always_comb begin
    data_o = '0;
    if (shamt_i[6]) begin
      data_o = '0;
    end else if (shamt_i[5]) begin
      data_o = {lo_sh, {WORD_W{1'b0}}};
    end else begin
      data_o = {hi_sh | carry, lo_sh};
    end
  end

endmodule

// File: rtl/rice_bit_aligner.sv
// rtl/rice_bit_aligner.sv - 64-bit MSB-first bit buffer presenting a 32-bit window to the Rice decoder
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   clr   in  1  synchronous clear of buffer, count and err
//   bus   slave modport of rice_bit_aligner_if (input words, window, consume, flush, err)
// Optional feature macro: RICE_ALIGN_FLUSH_EN exposes a partial (<32 bit) tail window while
// flush is high; without it flush is ignored.
// Buffer invariant: bits below bit_count (counted from the MSB) are always zero, so the
// window is zero padded and new words can simply be ORed in after the remaining bits.
module rice_bit_aligner
  import rice_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  rice_bit_aligner_if.slave  bus
);

  logic [BUF_W-1:0] bitbuf_q, bitbuf_d;
  bitcnt_t          cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             has_full;
  logic             win_valid_w;
  conslen_t         win_bits_w;
  logic             in_ready_w;
  logic             cons_req;
  logic             cons_ok;
  logic             push;
  bitcnt_t          cons_eff;
  bitcnt_t          rem;
  logic [BUF_W-1:0] cons_sh;
  logic [BUF_W-1:0] app_rev_sh;
  logic [BUF_W-1:0] app;

  assign has_full   = (cnt_q >= bitcnt_t'(WORD_W));
  assign win_bits_w = has_full ? conslen_t'(WORD_W) : cnt_q[LEN_W-1:0];
  assign in_ready_w = (cnt_q <= bitcnt_t'(WORD_W));

`ifdef RICE_ALIGN_FLUSH_EN
  assign win_valid_w = has_full | (bus.flush & (cnt_q != '0));
`else
  assign win_valid_w = has_full;
`endif

  // Zero-length consume is a no-op, never an error.
  assign cons_req = bus.cons_en & (bus.cons_len != '0);
  assign cons_ok  = cons_req & win_valid_w & (bus.cons_len <= win_bits_w);
  assign cons_eff = cons_ok ? {1'b0, bus.cons_len} : '0;
  assign push     = bus.in_valid & in_ready_w;
  // in_ready uses the pre-consume count, so rem <= 32 whenever push is taken.
  assign rem      = cnt_q - cons_eff;

  rice_shift64 u_cons_shift (
    .data_i  (bitbuf_q),
    .shamt_i (cons_eff),
    .data_o  (cons_sh)
  );

  // Placement {in_word,32'b0} >> rem done as a left shift of the bit-reversed word.
  rice_shift64 u_app_shift (
    .data_i  ({{WORD_W{1'b0}}, rev32(bus.in_word)}),
    .shamt_i (rem),
    .data_o  (app_rev_sh)
  );

  assign app = rev64(app_rev_sh);

  always_comb begin
    bitbuf_d = bitbuf_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (clr) begin
      bitbuf_d = '0;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else begin
      bitbuf_d = cons_sh | (push ? app : '0);
      cnt_d    = rem + (push ? bitcnt_t'(WORD_W) : '0);
      if (cons_req & ~cons_ok) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitbuf_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      bitbuf_q <= bitbuf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.win       = bitbuf_q[BUF_W-1:WORD_W];
  assign bus.win_valid = win_valid_w;
  assign bus.win_bits  = win_bits_w;
  assign bus.in_ready  = in_ready_w;
  assign bus.err       = err_q;

endmodule
